// File: rtl/capture_seq.sv
`default_nettype none
// ============================================================================
//  Module   : capture_seq
//  Purpose  : Triggered ADC capture sequencer. Divides the clock down to a
//             sample strobe and waits for a rising crossing of ADC_Data over
//             F_Gate. It then writes Buf_Depth consecutive samples to a
//             buffer and holds Done until the reader acknowledges.
//  Options  : CAPTURE_SEQ_AUTO_TRIG_EN -- when defined, a capture is forced
//             after Trig_Timeout strobes without a real trigger, and
//             Trig_Auto reports that the capture was forced.
//  Revision : 1.0  initial release
// ============================================================================
module capture_seq #(
   parameter int Buf_Depth    = 512,
   parameter int Addr_W       = 9,
   parameter int Trig_Timeout = 2000
) (
   input  logic              clk_100MHz,
   input  logic              Rst,
   input  logic              Start,
   input  logic              Abort,
   input  logic [20:0]       Period,
   input  logic [7:0]        ADC_Data,
   input  logic [7:0]        F_Gate,
   input  logic              Ack,
   output logic              Wr_En,
   output logic [Addr_W-1:0] Wr_Addr,
   output logic [7:0]        Wr_Data,
   output logic              Busy,
   output logic              Done,
   output logic              Trig_Auto
);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_TRIG = 2'd1,
      ST_CAPTURE   = 2'd2,
      ST_DONE      = 2'd3
   } state_t;

   localparam logic [Addr_W-1:0] c_last_addr = Addr_W'(Buf_Depth - 1);

   state_t            state_q,     state_d;
   logic [20:0]       period_q,    period_d;
   logic [20:0]       div_q,       div_d;
   logic              prev_q,      prev_d;
   logic              primed_q,    primed_d;
   logic [Addr_W-1:0] addr_q,      addr_d;
   logic              wr_en_q,     wr_en_d;
   logic [Addr_W-1:0] wr_addr_q,   wr_addr_d;
   logic [7:0]        wr_data_q,   wr_data_d;
   logic              busy_q,      busy_d;
   logic              done_q,      done_d;

   logic              w_strobe;
   logic              w_cmp;
   logic              w_real_trig;
   logic              w_auto_hit;

`ifdef CAPTURE_SEQ_AUTO_TRIG_EN
   logic [15:0]       tmo_q,       tmo_d;
   logic              trig_auto_q, trig_auto_d;

   // Timeout fires on the strobe whose count equals Trig_Timeout
   assign w_auto_hit = (tmo_q + 16'd1) == 16'(Trig_Timeout);
   assign Trig_Auto  = trig_auto_q;
`else
   logic [15:0]       unused_timeout;

   // Without the auto-trigger option WAIT_TRIG waits forever
   assign unused_timeout = 16'(Trig_Timeout);
   assign w_auto_hit     = 1'b0;
   assign Trig_Auto      = 1'b0;
`endif

   // Strobe decode and trigger comparison; the divider only runs while busy
   always_comb begin
      w_strobe    = ((state_q == ST_WAIT_TRIG) || (state_q == ST_CAPTURE)) &&
                    (div_q == (period_q - 21'd1));
      w_cmp       = (ADC_Data > F_Gate);
      w_real_trig = primed_q && !prev_q && w_cmp;
   end

   // Next-state and next-output computation for the whole sequencer
   always_comb begin
      state_d   = state_q;
      period_d  = period_q;
      div_d     = div_q;
      prev_d    = prev_q;
      primed_d  = primed_q;
      addr_d    = addr_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
`ifdef CAPTURE_SEQ_AUTO_TRIG_EN
      tmo_d       = tmo_q;
      trig_auto_d = trig_auto_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (Start) begin
               state_d  = ST_WAIT_TRIG;
               period_d = (Period == 21'd0) ? 21'd1 : Period;
               div_d    = 21'd0;
               prev_d   = 1'b0;
               primed_d = 1'b0;
               addr_d   = '0;
`ifdef CAPTURE_SEQ_AUTO_TRIG_EN
               tmo_d       = 16'd0;
               trig_auto_d = 1'b0;
`endif
            end
         end

         ST_WAIT_TRIG: begin
            if (Abort) begin
               state_d = ST_IDLE;
            end else begin
               div_d = w_strobe ? 21'd0 : (div_q + 21'd1);
               if (w_strobe) begin
                  prev_d   = w_cmp;
                  primed_d = 1'b1;
`ifdef CAPTURE_SEQ_AUTO_TRIG_EN
                  tmo_d = tmo_q + 16'd1;
`endif
                  // A real edge wins over a timeout on the same strobe
                  if (w_real_trig || w_auto_hit) begin
                     state_d   = ST_CAPTURE;
                     wr_en_d   = 1'b1;
                     wr_addr_d = '0;
                     wr_data_d = ADC_Data;
                     addr_d    = Addr_W'(1);
`ifdef CAPTURE_SEQ_AUTO_TRIG_EN
                     trig_auto_d = !w_real_trig;
`endif
                  end
               end
            end
         end

         ST_CAPTURE: begin
            if (Abort) begin
               state_d = ST_IDLE;
            end else begin
               div_d = w_strobe ? 21'd0 : (div_q + 21'd1);
               if (w_strobe) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = addr_q;
                  wr_data_d = ADC_Data;
                  if (addr_q == c_last_addr) begin
                     state_d = ST_DONE;
                  end else begin
                     addr_d = addr_q + Addr_W'(1);
                  end
               end
            end
         end

         ST_DONE: begin
            if (Ack) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d == ST_WAIT_TRIG) || (state_d == ST_CAPTURE);
      done_d = (state_d == ST_DONE);
   end

   // State and registered outputs; reset abandons any capture in flight
   always_ff @(posedge clk_100MHz or posedge Rst) begin
      if (Rst) begin
         state_q   <= ST_IDLE;
         period_q  <= 21'd0;
         div_q     <= 21'd0;
         prev_q    <= 1'b0;
         primed_q  <= 1'b0;
         addr_q    <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= 8'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef CAPTURE_SEQ_AUTO_TRIG_EN
         tmo_q       <= 16'd0;
         trig_auto_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         period_q  <= period_d;
         div_q     <= div_d;
         prev_q    <= prev_d;
         primed_q  <= primed_d;
         addr_q    <= addr_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
`ifdef CAPTURE_SEQ_AUTO_TRIG_EN
         tmo_q       <= tmo_d;
         trig_auto_q <= trig_auto_d;
`endif
      end
   end

   assign Wr_En   = wr_en_q;
   assign Wr_Addr = wr_addr_q;
   assign Wr_Data = wr_data_q;
   assign Busy    = busy_q;
   assign Done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_capture_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_capture_seq
//  Purpose  : Scoreboard bench for capture_seq (Buf_Depth=8, Trig_Timeout=5).
//             Expected buffer writes are queued as stimulus is issued and a
//             monitor pops and compares each Wr_En pulse.
//  Revision : 1.0  initial release
// ============================================================================
module tb_capture_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic        abort;
   logic [20:0] period;
   logic [7:0]  adc;
   logic [7:0]  f_gate;
   logic        ack;
   logic        wr_en;
   logic [2:0]  wr_addr;
   logic [7:0]  wr_data;
   logic        busy;
   logic        done;
   logic        trig_auto;

   typedef struct packed {
      logic [2:0] a;
      logic [7:0] d;
   } wr_t;

   wr_t exp_q[$];
   int  errors   = 0;
   int  checks   = 0;
   int  cyc      = 0;
   int  test_id  = 0;
   int  exp_gap  = 0;

   capture_seq #(
      .Buf_Depth    (8),
      .Addr_W       (3),
      .Trig_Timeout (5)
   ) dut (
      .clk_100MHz (clk),
      .Rst        (rst),
      .Start      (start),
      .Abort      (abort),
      .Period     (period),
      .ADC_Data   (adc),
      .F_Gate     (f_gate),
      .Ack        (ack),
      .Wr_En      (wr_en),
      .Wr_Addr    (wr_addr),
      .Wr_Data    (wr_data),
      .Busy       (busy),
      .Done       (done),
      .Trig_Auto  (trig_auto)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input int a, input int d);
      wr_t e;
      e.a = 3'(a);
      e.d = 8'(d);
      exp_q.push_back(e);
   endtask

   // Issue a one-cycle Start with the given period
   task automatic start_cap(input int p, input int gap);
      @(negedge clk);
      test_id++;
      exp_gap = gap;
      period  = 21'(p);
      start   = 1'b1;
      abort   = 1'b0;
      adc     = 8'd0;
   endtask

   // Sample n is the value present on the clock edge n cycles after Start
   task automatic drive_ramp(input int n0, input int n1, input int base,
                             input int step, input int abort_n);
      for (int n = n0; n <= n1; n++) begin
         @(negedge clk);
         start = 1'b0;
         adc   = 8'(base + step * n);
         abort = (n == abort_n);
      end
   endtask

   task automatic do_ack(input logic with_start);
      @(negedge clk);
      ack   = 1'b1;
      start = with_start;
      @(negedge clk);
      ack   = 1'b0;
      start = 1'b0;
      check("ack_done_low", int'(done), 0);
      check("ack_busy_low", int'(busy), 0);
      @(negedge clk);
      check("ack_start_ignored_busy", int'(busy), 0);
   endtask

   // Monitor: every write strobe must match the head of the scoreboard
   initial begin
      int  mon_id;
      int  last_cyc;
      wr_t e;
      mon_id   = -1;
      last_cyc = 0;
      forever begin
         @(negedge clk);
         if (wr_en) begin
            if (exp_q.size() == 0) begin
               check("wr_unexpected_addr", int'(wr_addr), -1);
            end else begin
               e = exp_q.pop_front();
               check("wr_addr", int'(wr_addr), int'(e.a));
               check("wr_data", int'(wr_data), int'(e.d));
            end
            if (mon_id == test_id && exp_gap > 0)
               check("wr_gap", cyc - last_cyc, exp_gap);
            mon_id   = test_id;
            last_cyc = cyc;
         end
      end
   end

   initial begin
      rst    = 1'b1;
      start  = 1'b0;
      abort  = 1'b0;
      ack    = 1'b0;
      period = 21'd0;
      adc    = 8'd0;
      f_gate = 8'd128;

      // Reset state
      #1;
      check("rst_wr_en",     int'(wr_en),     0);
      check("rst_wr_addr",   int'(wr_addr),   0);
      check("rst_wr_data",   int'(wr_data),   0);
      check("rst_busy",      int'(busy),      0);
      check("rst_done",      int'(done),      0);
      check("rst_trig_auto", int'(trig_auto), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Period=4, ramp 100+4n: strobes at n=4,8,...; n=4 -> 116 primes,
      // n=8 -> 132 triggers; addr k gets 132+16k. Period change mid-run
      // must not matter.
      for (int k = 0; k < 8; k++) push(k, 132 + 16 * k);
      start_cap(4, 4);
      check("wait_busy_idle_before", int'(busy), 0);
      drive_ramp(1, 2, 100, 4, 0);
      check("wait_busy", int'(busy), 1);
      period = 21'd7;
      drive_ramp(3, 40, 100, 4, 0);
      check("a_done", int'(done), 1);
      check("a_busy", int'(busy), 0);
      check("a_trig_auto", int'(trig_auto), 0);
      check("a_queue_empty", exp_q.size(), 0);
      do_ack(1'b1);

      // Period=0 -> strobe every clock; ramp 120+5n: n=1 -> 125 primes,
      // n=2 -> 130 triggers; addr k gets 130+5k back to back
      for (int k = 0; k < 8; k++) push(k, 130 + 5 * k);
      start_cap(0, 1);
      drive_ramp(1, 12, 120, 5, 0);
      check("b_done", int'(done), 1);
      check("b_queue_empty", exp_q.size(), 0);
      do_ack(1'b0);

`ifdef CAPTURE_SEQ_AUTO_TRIG_EN
      // Data always above the gate: no real edge, timeout on strobe 5
      // (n=5, data 205); addr k gets 205+k
      for (int k = 0; k < 8; k++) push(k, 205 + k);
      start_cap(1, 1);
      drive_ramp(1, 15, 200, 1, 0);
      check("c_done", int'(done), 1);
      check("c_trig_auto", int'(trig_auto), 1);
      check("c_queue_empty", exp_q.size(), 0);
      do_ack(1'b0);
`else
      // Data held at 200: no edge, so the sequencer waits with no writes
      start_cap(1, 1);
      drive_ramp(1, 100, 200, 0, 0);
      check("c_busy_waiting", int'(busy), 1);
      check("c_done_low", int'(done), 0);
      check("c_trig_auto", int'(trig_auto), 0);
      drive_ramp(101, 101, 200, 0, 101);
      @(negedge clk);
      abort = 1'b0;
      check("c_abort_busy", int'(busy), 0);
`endif

      // Abort after three writes (n=2,3,4); abort on n=5 kills that write
      push(0, 130);
      push(1, 135);
      push(2, 140);
      start_cap(0, 1);
      drive_ramp(1, 6, 120, 5, 5);
      check("d_abort_busy", int'(busy), 0);
      drive_ramp(7, 20, 120, 5, 0);
      check("d_abort_done", int'(done), 0);
      check("d_abort_busy_later", int'(busy), 0);
      check("d_queue_empty", exp_q.size(), 0);

      // Reset right after the trigger edge: the pending write is killed
      start_cap(0, 1);
      drive_ramp(1, 2, 120, 5, 0);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("e_rst_wr_en",   int'(wr_en),   0);
      check("e_rst_wr_addr", int'(wr_addr), 0);
      check("e_rst_wr_data", int'(wr_data), 0);
      check("e_rst_busy",    int'(busy),    0);
      check("e_rst_done",    int'(done),    0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      drive_ramp(1, 10, 120, 5, 0);
      check("e_idle_after_rst", int'(busy), 0);
      for (int k = 0; k < 8; k++) push(k, 130 + 5 * k);
      start_cap(0, 1);
      drive_ramp(1, 12, 120, 5, 0);
      check("e_done", int'(done), 1);
      check("e_queue_empty", exp_q.size(), 0);
      do_ack(1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/capture_seq.md
CAPTURE_SEQ -- requirements
Module: capture_seq

Interface
REQ-001 Parameter Buf_Depth, default 512: number of samples per capture; power of two, 2..4096.
REQ-002 Parameter Addr_W, default 9: equals log2(Buf_Depth).
REQ-003 Parameter Trig_Timeout, default 2000: strobes without a trigger before auto-trigger fires; range 1..65535.
REQ-004 clk_100MHz  in  1  system clock; all logic on rising edge.
REQ-005 Rst  in  1  asynchronous, active-high reset.
REQ-006 Start  in  1  one-cycle request to begin a capture.
REQ-007 Abort  in  1  cancels a capture in progress.
REQ-008 Period  in  21  sample interval in clocks, from the frequency-measurement block.
REQ-009 ADC_Data  in  8  ADC sample.
REQ-010 F_Gate  in  8  trigger threshold.
REQ-011 Wr_En  out  1  buffer write strobe.
REQ-012 Wr_Addr  out  Addr_W  buffer write address.
REQ-013 Wr_Data  out  8  buffer write data.
REQ-014 Busy  out  1  capture in progress.
REQ-015 Done  out  1  buffer full, awaiting Ack.
REQ-016 Ack  in  1  reader has consumed the buffer.
REQ-017 Trig_Auto  out  1  last capture was started by timeout.

Function
REQ-018 States: IDLE, WAIT_TRIG, CAPTURE, DONE; every output is registered.
REQ-019 IDLE + Start: latch Period (0 treated as 1), clear the divider, clear Trig_Auto, move to WAIT_TRIG; Start is ignored in every other state.
REQ-020 Sample strobe: the divider counts 0..P-1 and strobes when it reaches P-1, giving one strobe every P clocks; P=1 strobes every clock; the divider runs only in WAIT_TRIG and CAPTURE.
REQ-021 At each strobe, cmp = (ADC_Data > F_Gate), unsigned.
REQ-022 The first strobe in WAIT_TRIG only records cmp as prev and writes nothing.
REQ-023 Trigger event: a later strobe in WAIT_TRIG with prev=0 and cmp=1; that sample goes to address 0 and the state moves to CAPTURE.
REQ-024 CAPTURE: each strobe writes the next sample at the next address.
REQ-025 After the write to address Buf_Depth-1, move to DONE; the address never wraps within a capture.
REQ-026 Write timing: Wr_En is high for exactly one cycle, the cycle after the strobe; Wr_Data is ADC_Data sampled on the strobe cycle; Wr_Addr is valid while Wr_En is high.
REQ-027 Each capture writes exactly Buf_Depth samples.
REQ-028 Busy is high in WAIT_TRIG and CAPTURE; Done is high in DONE.
REQ-029 DONE + Ack: go to IDLE on the next cycle; if Start and Ack arrive together, Start is ignored.
REQ-030 Abort in WAIT_TRIG or CAPTURE: go to IDLE on the next cycle, Done is not asserted, and any strobe in that same cycle writes nothing.
REQ-031 Abort in IDLE or DONE: no effect.
REQ-032 Abort has priority over a same-cycle trigger or final write.
REQ-033 Period changes after the latch in REQ-019 have no effect until the next Start.

Reset
REQ-034 Rst asserted: state=IDLE; Wr_En=0, Wr_Addr=0, Wr_Data=0, Busy=0, Done=0, Trig_Auto=0; divider, prev and timeout counter cleared.
REQ-035 Rst mid-capture abandons the capture with no further writes; operation resumes only after a new Start following reset release.

Configuration
REQ-036 Macro CAPTURE_SEQ_AUTO_TRIG_EN defined: the timeout counter counts strobes in WAIT_TRIG.
REQ-037 With the macro defined, when the count reaches Trig_Timeout with no trigger, that strobe is treated as a trigger, written to address 0, and Trig_Auto is set.
REQ-038 A real trigger on the same strobe as the timeout is treated as real (Trig_Auto=0).
REQ-039 Macro undefined: WAIT_TRIG waits indefinitely, Trig_Auto is constant 0, and no timeout counter exists.

Verification
REQ-040 Period=4, Buf_Depth=8, ADC ramp crossing F_Gate=128 -> 8 Wr_En pulses spaced 4 clocks apart, addr 0..7, first sample >128; Done then high; Ack -> IDLE the next cycle.
REQ-041 Period=0 -> strobe every clock; 8 consecutive Wr_En pulses after the trigger.
REQ-042 ADC_Data held at 200 > F_Gate=128 with macro defined, Trig_Timeout=5 -> no real edge; auto-trigger on strobe 5; Trig_Auto=1.
REQ-043 Same stimulus as REQ-042 with macro undefined -> Busy stays high with no writes for 100 strobes.
REQ-044 Abort during CAPTURE after 3 writes -> Busy=0 the next cycle, Done never asserts, no further Wr_En.
REQ-045 Rst pulse during CAPTURE -> all outputs 0 immediately; Start after release -> a capture restarting at address 0.
